// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter: read-owner encoding and
// the all-ones write-enable value that marks a read access.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } rd_owner_e;

  localparam logic [1:0] WEN_READ = 2'b11;

  function automatic logic is_read(input logic [1:0] wen);
    return (wen == WEN_READ);
  endfunction

endpackage

// File: rtl/ram_arb_starve.sv
// Saturating DMA starvation counter: counts consecutive denied DMA requests
// and flags when DMA has waited long enough to win the next slot.
module ram_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       dma_req_i,
  input  logic       dma_gnt_i,
  output logic [3:0] cnt_o,
  output logic       starved_o
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Any grant or a dropped request ends the starvation streak.
  always_comb begin
    cnt_d = cnt_q;
    if (!dma_req_i || dma_gnt_i) begin
      cnt_d = 4'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign starved_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ram_arbiter.sv
// Two-master (CPU/DMA) single-port RAM arbiter with combinational grant,
// starvation relief for DMA and one-cycle read-return tagging.
// Optional DMA burst lock is built when RAM_ARB_LOCK_EN is defined.
//
// Handshake: a master holds *_req with its address/wen/din; the access is
// issued to RAM in any cycle where *_gnt is high (same cycle, no hold needed
// afterwards). For reads, *_rvalid is high exactly one cycle later and
// qualifies *_dout; there is no back-pressure on the return path.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_MSB   = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic              mclk,
  input  logic              puc_rst_n,

  input  logic              cpu_req,
  input  logic [ADDR_MSB:0] cpu_addr,
  input  logic [1:0]        cpu_wen,
  input  logic [15:0]       cpu_din,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [15:0]       cpu_dout,

  input  logic              dma_req,
  input  logic [ADDR_MSB:0] dma_addr,
  input  logic [1:0]        dma_wen,
  input  logic [15:0]       dma_din,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [15:0]       dma_dout,
`ifdef RAM_ARB_LOCK_EN
  input  logic              dma_lock,
`endif

  output logic              ram_cen,
  output logic [ADDR_MSB:0] ram_addr,
  output logic [1:0]        ram_wen,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout,

  output logic [3:0]        dbg_starve_cnt,
  output logic [1:0]        dbg_rd_owner
);

  logic      starved;
  logic      lock_act;
  rd_owner_e rd_owner_q;
  rd_owner_e rd_owner_d;

  ram_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk_i     (mclk),
    .rst_n_i   (puc_rst_n),
    .dma_req_i (dma_req),
    .dma_gnt_i (dma_gnt),
    .cnt_o     (dbg_starve_cnt),
    .starved_o (starved)
  );

`ifdef RAM_ARB_LOCK_EN
  logic lock_q;
  logic lock_d;

  // Lock survives only while each granted DMA cycle keeps dma_lock high.
  assign lock_d   = dma_gnt & dma_lock;
  assign lock_act = lock_q;

  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  assign lock_act = 1'b0;
`endif

  // Grants are gated by reset so nothing reaches the RAM during reset.
  always_comb begin
    dma_gnt = puc_rst_n & dma_req & (~cpu_req | starved | lock_act);
    cpu_gnt = puc_rst_n & cpu_req & ~dma_gnt;
  end

  always_comb begin
    ram_addr = '0;
    ram_wen  = WEN_READ;
    ram_din  = 16'h0000;
    if (cpu_gnt) begin
      ram_addr = cpu_addr;
      ram_wen  = cpu_wen;
      ram_din  = cpu_din;
    end else if (dma_gnt) begin
      ram_addr = dma_addr;
      ram_wen  = dma_wen;
      ram_din  = dma_din;
    end
  end

  assign ram_cen = ~(cpu_gnt | dma_gnt);

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (cpu_gnt && is_read(cpu_wen)) begin
      rd_owner_d = OWN_CPU;
    end else if (dma_gnt && is_read(dma_wen)) begin
      rd_owner_d = OWN_DMA;
    end
  end

  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // Masking with reset drops a read return that would land inside reset.
  assign cpu_rvalid   = puc_rst_n & (rd_owner_q == OWN_CPU);
  assign dma_rvalid   = puc_rst_n & (rd_owner_q == OWN_DMA);
  assign cpu_dout     = ram_dout;
  assign dma_dout     = ram_dout;
  assign dbg_rd_owner = rd_owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 128x16 RAM model.
// Lock scenario is included when RAM_ARB_LOCK_EN is defined.
module tb_ram_arbiter;

  localparam int ADDR_MSB = 6;

  logic              mclk;
  logic              puc_rst_n;
  logic              cpu_req, dma_req;
  logic [ADDR_MSB:0] cpu_addr, dma_addr;
  logic [1:0]        cpu_wen, dma_wen;
  logic [15:0]       cpu_din, dma_din;
  logic              cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
  logic [15:0]       cpu_dout, dma_dout;
`ifdef RAM_ARB_LOCK_EN
  logic              dma_lock;
`endif
  logic              ram_cen;
  logic [ADDR_MSB:0] ram_addr;
  logic [1:0]        ram_wen;
  logic [15:0]       ram_din;
  logic [15:0]       ram_dout;
  logic [3:0]        dbg_starve_cnt;
  logic [1:0]        dbg_rd_owner;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.ADDR_MSB(ADDR_MSB), .STARVE_MAX(4)) dut (
    .mclk           (mclk),
    .puc_rst_n      (puc_rst_n),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_wen        (cpu_wen),
    .cpu_din        (cpu_din),
    .cpu_gnt        (cpu_gnt),
    .cpu_rvalid     (cpu_rvalid),
    .cpu_dout       (cpu_dout),
    .dma_req        (dma_req),
    .dma_addr       (dma_addr),
    .dma_wen        (dma_wen),
    .dma_din        (dma_din),
    .dma_gnt        (dma_gnt),
    .dma_rvalid     (dma_rvalid),
    .dma_dout       (dma_dout),
`ifdef RAM_ARB_LOCK_EN
    .dma_lock       (dma_lock),
`endif
    .ram_cen        (ram_cen),
    .ram_addr       (ram_addr),
    .ram_wen        (ram_wen),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .dbg_starve_cnt (dbg_starve_cnt),
    .dbg_rd_owner   (dbg_rd_owner)
  );

  // Clock / reset
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // RAM model: byte write enables active-low, read data one cycle later.
  logic [15:0]       mem [0:127];
  logic              load_en;
  logic [ADDR_MSB:0] load_addr;
  logic [15:0]       load_data;

  always @(posedge mclk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (!ram_cen) begin
      if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
      if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
      ram_dout <= mem[ram_addr];
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic set_idle();
    cpu_req  = 1'b0; cpu_addr = '0; cpu_wen = 2'b11; cpu_din = 16'h0;
    dma_req  = 1'b0; dma_addr = '0; dma_wen = 2'b11; dma_din = 16'h0;
`ifdef RAM_ARB_LOCK_EN
    dma_lock = 1'b0;
`endif
  endtask

  task automatic preload(input logic [ADDR_MSB:0] a, input logic [15:0] d);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    tick();
    load_en   = 1'b0;
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    load_en = 1'b0; load_addr = '0; load_data = '0;
    puc_rst_n = 1'b0;
    set_idle();
    cpu_req = 1'b1;
    dma_req = 1'b1;
    tick();
    preload(7'h05, 16'hBEEF);
    preload(7'h09, 16'h3456);
    preload(7'h0A, 16'h1111);
    preload(7'h0B, 16'h2222);

    // Reset state with requests asserted
    #1;
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_dma_gnt", dma_gnt, 0);
    check("rst_cen", ram_cen, 1);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_dma_rvalid", dma_rvalid, 0);
    check("rst_starve", dbg_starve_cnt, 0);
    check("rst_owner", dbg_rd_owner, 0);

    puc_rst_n = 1'b1;
    set_idle();
    tick();
    check("idle_cen", ram_cen, 1);
    check("idle_addr", ram_addr, 0);
    check("idle_wen", ram_wen, 2'b11);
    check("idle_din", ram_din, 0);

    // CPU-only read of 0xBEEF at 0x05
    cpu_req = 1'b1; cpu_addr = 7'h05; cpu_wen = 2'b11;
    #1;
    check("rd_cpu_gnt", cpu_gnt, 1);
    check("rd_dma_gnt", dma_gnt, 0);
    check("rd_cen", ram_cen, 0);
    check("rd_addr", ram_addr, 7'h05);
    tick();
    set_idle();
    check("rd_cpu_rvalid", cpu_rvalid, 1);
    check("rd_cpu_dout", cpu_dout, 16'hBEEF);
    check("rd_dma_rvalid", dma_rvalid, 0);
    tick();
    check("rd_rvalid_one_cycle", cpu_rvalid, 0);

    // DMA partial write: high byte only
    dma_req = 1'b1; dma_addr = 7'h09; dma_wen = 2'b01; dma_din = 16'h12AB;
    #1;
    check("wr_dma_gnt", dma_gnt, 1);
    check("wr_ram_wen", ram_wen, 2'b01);
    check("wr_ram_din", ram_din, 16'h12AB);
    tick();
    set_idle();
    check("wr_no_rvalid", dma_rvalid, 0);
    check("wr_mem", mem[9], 16'h1256);
    cpu_req = 1'b1; cpu_addr = 7'h09;
    tick();
    set_idle();
    check("wr_readback", cpu_dout, 16'h1256);
    check("wr_readback_v", cpu_rvalid, 1);

    // Contention: CPU wins 4 cycles, DMA the 5th
    cpu_req = 1'b1; cpu_addr = 7'h0A;
    dma_req = 1'b1; dma_addr = 7'h0B;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_cpu_gnt", cpu_gnt, 1);
      check("cont_dma_gnt", dma_gnt, 0);
      check("cont_starve", dbg_starve_cnt, i);
      tick();
      check("cont_cpu_dout", cpu_dout, 16'h1111);
      check("cont_cpu_rvalid", cpu_rvalid, 1);
    end
    #1;
    check("starve_sat", dbg_starve_cnt, 4);
    check("starve_dma_gnt", dma_gnt, 1);
    check("starve_cpu_gnt", cpu_gnt, 0);
    check("starve_addr", ram_addr, 7'h0B);
    tick();
    check("starve_cleared", dbg_starve_cnt, 0);
    check("starve_dma_rvalid", dma_rvalid, 1);
    check("starve_cpu_rvalid", cpu_rvalid, 0);
    check("starve_dma_dout", dma_dout, 16'h2222);
    tick();
    check("starve_restart", dbg_starve_cnt, 1);
    dma_req = 1'b0;
    tick();
    check("starve_drop_clear", dbg_starve_cnt, 0);
    set_idle();
    tick();

    // Alternating owners, no bubble
    cpu_req = 1'b1; cpu_addr = 7'h0A;
    tick();
    check("alt1_cpu_rvalid", cpu_rvalid, 1);
    check("alt1_dma_rvalid", dma_rvalid, 0);
    check("alt1_dout", cpu_dout, 16'h1111);
    cpu_req = 1'b0; dma_req = 1'b1; dma_addr = 7'h0B;
    #1;
    check("alt2_dma_gnt", dma_gnt, 1);
    tick();
    check("alt2_dma_rvalid", dma_rvalid, 1);
    check("alt2_cpu_rvalid", cpu_rvalid, 0);
    check("alt2_dout", dma_dout, 16'h2222);
    dma_req = 1'b0; cpu_req = 1'b1; cpu_addr = 7'h05;
    tick();
    check("alt3_cpu_rvalid", cpu_rvalid, 1);
    check("alt3_dma_rvalid", dma_rvalid, 0);
    check("alt3_dout", cpu_dout, 16'hBEEF);
    set_idle();
    tick();

    // Read granted, then reset asserted
    cpu_req = 1'b1; cpu_addr = 7'h05;
    #1;
    check("rr_cpu_gnt", cpu_gnt, 1);
    tick();
    puc_rst_n = 1'b0;
    #1;
    check("rr_rvalid", cpu_rvalid, 0);
    check("rr_gnt", cpu_gnt, 0);
    check("rr_cen", ram_cen, 1);
    tick();
    check("rr_owner", dbg_rd_owner, 0);
    check("rr_rvalid2", cpu_rvalid, 0);
    check("rr_cen2", ram_cen, 1);
    puc_rst_n = 1'b1;
    set_idle();
    tick();

`ifdef RAM_ARB_LOCK_EN
    // DMA burst lock holds off CPU
    dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 7'h0B;
    #1;
    check("lk1_dma_gnt", dma_gnt, 1);
    tick();
    cpu_req = 1'b1; cpu_addr = 7'h0A;
    #1;
    check("lk2_dma_gnt", dma_gnt, 1);
    check("lk2_cpu_gnt", cpu_gnt, 0);
    tick();
    dma_lock = 1'b0;
    #1;
    check("lk3_dma_gnt", dma_gnt, 1);
    check("lk3_cpu_gnt", cpu_gnt, 0);
    tick();
    #1;
    check("lk4_cpu_gnt", cpu_gnt, 1);
    check("lk4_dma_gnt", dma_gnt, 0);
    set_idle();
    tick();
`endif

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
